// File: rtl/ffd_bank_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// FFD_ARB_GRANT_CNT_EN adds the grant_cnt_out event counter.
interface ffd_bank_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    logic [NREQ-1:0]       req_in;
    logic [NREQ-1:0]       wr_in;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt_out;
    logic                  busy_out;
    logic [WIDTH-1:0]      q_out;
    logic                  wr_ack_out;
`ifdef FFD_ARB_GRANT_CNT_EN
    logic [7:0]            grant_cnt_out;

    modport master (
        output req_in, wr_in, data_in,
        input  gnt_out, busy_out, q_out, wr_ack_out, grant_cnt_out
    );
    modport slave (
        input  req_in, wr_in, data_in,
        output gnt_out, busy_out, q_out, wr_ack_out, grant_cnt_out
    );
`else
    modport master (
        output req_in, wr_in, data_in,
        input  gnt_out, busy_out, q_out, wr_ack_out
    );
    modport slave (
        input  req_in, wr_in, data_in,
        output gnt_out, busy_out, q_out, wr_ack_out
    );
`endif
endinterface

// File: rtl/ffd_bank_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register, with a per-grant hold limit.
// FFD_ARB_GRANT_CNT_EN adds a saturating 8-bit grant event counter.
module ffd_bank_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst_in,
    ffd_bank_arbiter_if.slave bus
);
    localparam int unsigned IdxW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HoldMax = (MAX_HOLD > 0) ? MAX_HOLD : 1;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              ack_q, ack_d;
    logic [NREQ-1:0]   others;
    logic              hold_sat;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First asserted request scanning start, start+1, ... with wrap.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [IdxW-1:0] start);
        logic [IdxW-1:0] idx;
        logic [IdxW-1:0] pick;
        logic            found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return pick;
    endfunction

    assign others   = bus.req_in & ~gnt_q;
    assign hold_sat = (hold_q == HoldW'(HoldMax));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req_in) begin
                    owner_d = rr_pick(bus.req_in, ptr_q);
                    gnt_d   = NREQ'(1) << owner_d;
                    hold_d  = HoldW'(1);
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (bus.req_in[owner_q] && bus.wr_in[owner_q]) begin
                    data_d = bus.data_in[32'(owner_q)*WIDTH +: WIDTH];
                    ack_d  = 1'b1;
                end
                // Release and hold-limit preemption hand over identically.
                if (!bus.req_in[owner_q] || ((MAX_HOLD > 0) && hold_sat && (|others))) begin
                    ptr_d = next_idx(owner_q);
                    if (|others) begin
                        owner_d = rr_pick(others, next_idx(owner_q));
                        gnt_d   = NREQ'(1) << owner_d;
                        hold_d  = HoldW'(1);
                    end else begin
                        gnt_d   = '0;
                        hold_d  = '0;
                        state_d = StIdle;
                    end
                end else if (!hold_sat) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.gnt_out    = gnt_q;
    assign bus.busy_out   = |gnt_q;
    assign bus.q_out      = data_q;
    assign bus.wr_ack_out = ack_q;

`ifdef FFD_ARB_GRANT_CNT_EN
    logic [7:0] gcnt_q;
    logic       grant_evt;

    // Owner never hands over to itself, so an owner change marks a handover.
    assign grant_evt = (state_d == StGrant) &&
                       ((state_q == StIdle) || (owner_d != owner_q));

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            gcnt_q <= '0;
        end else if (grant_evt && (gcnt_q != 8'hFF)) begin
            gcnt_q <= gcnt_q + 8'd1;
        end
    end

    assign bus.grant_cnt_out = gcnt_q;
`endif
endmodule

// File: tb/tb_ffd_bank_arbiter.sv
// Scoreboard bench: stimulus queues expected post-edge outputs, a monitor pops and compares.
module tb_ffd_bank_arbiter;
    logic clk;
    logic rst_in;
    int   checks   = 0;
    int   failures = 0;

    // {gnt[3:0], busy, q[7:0], ack}
    logic [13:0] exp_q[$];
    string       name_q[$];

    ffd_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    ffd_bank_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 ns");
        $fatal(1);
    end

    function automatic logic [13:0] actual();
        return {bus.gnt_out, bus.busy_out, bus.q_out, bus.wr_ack_out};
    endfunction

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got gnt=%b busy=%b q=%h ack=%b, want gnt=%b busy=%b q=%h ack=%b",
                     nm, act[13:10], act[9], act[8:1], act[0],
                     exp[13:10], exp[9], exp[8:1], exp[0]);
        end
    endtask

    task automatic expect_next(input string nm, input logic [3:0] eg, input logic [7:0] eq,
                               input logic ea);
        exp_q.push_back({eg, |eg, eq, ea});
        name_q.push_back(nm);
    endtask

    task automatic cyc(input string nm, input logic [3:0] r, input logic [3:0] w,
                       input logic [31:0] d, input logic [3:0] eg, input logic [7:0] eq,
                       input logic ea);
        @(negedge clk);
        bus.req_in  = r;
        bus.wr_in   = w;
        bus.data_in = d;
        expect_next(nm, eg, eq, ea);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic pulse_reset(input string nm);
        @(negedge clk);
        #2 rst_in = 1'b1;
        #1 check(nm, actual(), 14'h0);
        #1 rst_in = 1'b0;
    endtask

    initial begin : monitor
        logic [13:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, actual(), e);
            end
        end
    end

    initial begin : stimulus
        bus.req_in  = '0;
        bus.wr_in   = '0;
        bus.data_in = '0;
        rst_in      = 1'b1;
        #20;
        #2 rst_in = 1'b0;
        check("reset", actual(), 14'h0);

        // Single requester write; foreign and unrequested writes ignored.
        cyc("single_gnt",   4'b0010, 4'b0000, 32'h0000_0000, 4'b0010, 8'h00, 1'b0);
        cyc("single_wr",    4'b0010, 4'b0010, 32'h0000_A500, 4'b0010, 8'hA5, 1'b1);
        cyc("foreign_wr",   4'b0010, 4'b0100, 32'h003C_FF00, 4'b0010, 8'hA5, 1'b0);
        cyc("noreq_wr",     4'b0000, 4'b0010, 32'h0000_1100, 4'b0000, 8'hA5, 1'b0);

        // Early release with a pending requester, then release to idle.
        cyc("early_gnt2",   4'b1100, 4'b0000, 32'h0, 4'b0100, 8'hA5, 1'b0);
        cyc("handover3",    4'b1000, 4'b0000, 32'h0, 4'b1000, 8'hA5, 1'b0);
        cyc("idle_again",   4'b0000, 4'b0000, 32'h0, 4'b0000, 8'hA5, 1'b0);

        // All requesting from reset: 4-cycle tenures 0,1,2,3,0 with no bubbles.
        pulse_reset("reset_pulse");
        for (int n = 1; n <= 17; n++) begin
            cyc("rr_all", 4'b1111, 4'b0000, 32'h0, 4'(1 << (((n - 1) / 4) % 4)), 8'h00, 1'b0);
        end
        cyc("rr_release",   4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0);

        // Lone owner saturates hold, then is preempted; its final-cycle write lands.
        for (int n = 0; n < 10; n++) begin
            cyc("hold_sat", 4'b0001, 4'b0000, 32'h0, 4'b0001, 8'h00, 1'b0);
        end
        cyc("preempt_wr",   4'b0011, 4'b0001, 32'h0000_005A, 4'b0010, 8'h5A, 1'b1);
        cyc("new_owner",    4'b0011, 4'b0000, 32'h0, 4'b0010, 8'h5A, 1'b0);
        cyc("sat_release",  4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h5A, 1'b0);

        // Async reset mid-write: write lost, ptr back to 0 so 0110 grants requester 1.
        cyc("pre_rst_gnt1", 4'b0010, 4'b0000, 32'h0, 4'b0010, 8'h5A, 1'b0);
        @(negedge clk);
        bus.req_in  = 4'b0010;
        bus.wr_in   = 4'b0010;
        bus.data_in = 32'h0000_7700;
        #2 rst_in = 1'b1;
        #1 check("async_rst", actual(), 14'h0);
        bus.req_in  = 4'b0110;
        bus.wr_in   = 4'b0000;
        bus.data_in = 32'h0;
        #1 rst_in = 1'b0;
        expect_next("post_rst_gnt", 4'b0010, 8'h00, 1'b0);
        cyc("post_rst_drop", 4'b0100, 4'b0000, 32'h0, 4'b0100, 8'h00, 1'b0);
        cyc("final_idle",    4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
